// File: rtl/kmeans_pkg.sv
// Shared types and width constants for the k-means centroid update path.
package kmeans_pkg;

  localparam int CORD_W     = 13;
  localparam int ACC_CORD_W = 22;
  localparam int COUNT_W    = 10;
  localparam int DATA_W     = 91;
  localparam int NUM_COORD  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_DIV,
    S_EMIT,
    S_WAIT_RES,
    S_DONE
  } state_t;

  // Coordinate 1 sits in the LSBs of the packed accumulator word.
  function automatic logic [ACC_CORD_W-1:0] acc_slice(
    input logic [NUM_COORD*ACC_CORD_W-1:0] acc,
    input int unsigned                     c
  );
    return acc[c*ACC_CORD_W +: ACC_CORD_W];
  endfunction

endpackage

// File: rtl/centroid_update_sequencer_coord_divider.sv
// Serial unsigned restoring divider, one quotient bit per cycle, with the
// quotient saturated to Q_W bits. The result register holds until the next load/clr.
module coord_divider
  import kmeans_pkg::*;
#(
  parameter int DVD_W = ACC_CORD_W,
  parameter int DSR_W = COUNT_W,
  parameter int Q_W   = CORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd;
  logic [DVD_W-2:0] q;
  logic [DSR_W-1:0] dsr;
  logic [DSR_W-1:0] rem;
  logic [DSR_W:0]   trial;
  logic             fits;
  logic [DSR_W-1:0] rem_nxt;
  logic [DVD_W-1:0] q_nxt;

  function automatic logic [Q_W-1:0] sat_q(input logic [DVD_W-1:0] v);
    if (|v[DVD_W-1:Q_W]) return '1;
    return v[Q_W-1:0];
  endfunction

  // Remainder stays below the divisor, so the subtraction fits in DSR_W bits.
  always_comb begin
    trial   = {rem, dvd[DVD_W-1]};
    fits    = trial >= {1'b0, dsr};
    rem_nxt = fits ? (trial[DSR_W-1:0] - dsr) : trial[DSR_W-1:0];
    q_nxt   = {q, fits};
  end

  assign busy = (cnt != '0);
  // High during the cycle that produces the final quotient bit.
  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      quotient <= '0;
    end else if (clr) begin
      cnt      <= '0;
      quotient <= '0;
    end else if (load) begin
      cnt <= CNT_W'(DVD_W);
      dvd <= dividend;
      dsr <= divisor;
      rem <= '0;
      q   <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      dvd <= {dvd[DVD_W-2:0], 1'b0};
      rem <= rem_nxt;
      q   <= q_nxt[DVD_W-2:0];
      if (done) quotient <= sat_q(q_nxt);
    end
  end

endmodule

// File: rtl/centroid_update_sequencer.sv
// Per-iteration centroid update: fetch sums/counts, divide, stream centroids to
// the convergence checker, collect the verdict. KMEANS_ROUND_DIV_EN selects round-to-nearest.
module centroid_update_sequencer
  import kmeans_pkg::*;
#(
  parameter int centroid_num     = 8,
  parameter int cordinate_width  = CORD_W,
  parameter int accum_cord_width = ACC_CORD_W,
  parameter int accum_width      = NUM_COORD * ACC_CORD_W,
  parameter int count_width      = COUNT_W,
  parameter int dataWidth        = DATA_W,
  parameter int iter_width       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear_iter,
  input  logic [iter_width-1:0]  max_iter,
  output logic                   sum_req,
  output logic [2:0]             sum_idx,
  input  logic [accum_width-1:0] accum_sum_in,
  input  logic [count_width-1:0] count_in,
  output logic [dataWidth-1:0]   new_centroid,
  output logic [2:0]             cent_num,
  output logic                   divide_by_0,
  output logic                   convergence_reg_en,
  output logic                   convergence_regs_reset_n,
  input  logic                   has_converged,
  input  logic                   converge_res_available,
  output logic                   iter_done,
  output logic                   converged,
  output logic                   stop,
  output logic [iter_width-1:0]  iter_count
);

`ifdef KMEANS_ROUND_DIV_EN
  localparam int DIV_W = accum_cord_width + 1;
`else
  localparam int DIV_W = accum_cord_width;
`endif

  state_t                state, state_nxt;
  logic [2:0]            idx;
  logic                  dz;
  logic                  div_load, div_clr;
  logic [NUM_COORD-1:0]  div_busy, div_done;
  logic [iter_width-1:0] iter_nxt;

  for (genvar g = 0; g < NUM_COORD; g++) begin : g_div
    logic [accum_cord_width-1:0] sum_c;
    logic [DIV_W-1:0]            dividend;

    assign sum_c = acc_slice(accum_sum_in, g);
`ifdef KMEANS_ROUND_DIV_EN
    // Adding half the divisor turns the truncating divide into round-to-nearest.
    assign dividend = {1'b0, sum_c} + DIV_W'(count_in >> 1);
`else
    assign dividend = sum_c;
`endif

    coord_divider #(
      .DVD_W(DIV_W),
      .DSR_W(count_width),
      .Q_W  (cordinate_width)
    ) u_div (
      .clk     (clk),
      .rst     (rst),
      .load    (div_load),
      .clr     (div_clr),
      .dividend(dividend),
      .divisor (count_in),
      .busy    (div_busy[g]),
      .done    (div_done[g]),
      .quotient(new_centroid[g*cordinate_width +: cordinate_width])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt                = state;
    div_load                 = 1'b0;
    div_clr                  = 1'b0;
    sum_req                  = (state == S_FETCH);
    sum_idx                  = idx;
    convergence_reg_en       = (state == S_EMIT);
    // The checker evaluates whenever cent_num==7, so it must read 0 outside EMIT.
    cent_num                 = (state == S_EMIT) ? idx : 3'd0;
    divide_by_0              = (state == S_EMIT) && dz;
    iter_done                = (state == S_DONE);
    convergence_regs_reset_n = !(rst || (state == S_CLEAR));
    case (state)
      S_IDLE:     if (start && !stop) state_nxt = S_CLEAR;
      S_CLEAR:    state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_LOAD;
      S_LOAD: begin
        if (count_in == '0) begin
          div_clr   = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          div_load  = 1'b1;
          state_nxt = S_DIV;
        end
      end
      // Leaving on an idle divider bank keeps a lost load from hanging the pass.
      S_DIV:      if ((&div_done) || !(|div_busy)) state_nxt = S_EMIT;
      S_EMIT:     state_nxt = (idx == 3'(centroid_num - 1)) ? S_WAIT_RES : S_FETCH;
      S_WAIT_RES: if (converge_res_available) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign iter_nxt = (&iter_count) ? iter_count : iter_count + iter_width'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 3'd0;
      dz         <= 1'b0;
      converged  <= 1'b0;
      stop       <= 1'b0;
      iter_count <= '0;
    end else begin
      if (state == S_CLEAR) idx <= 3'd0;
      else if (state == S_EMIT && state_nxt == S_FETCH) idx <= idx + 3'd1;
      if (state == S_LOAD) dz <= (count_in == '0);
      if (state == S_WAIT_RES && converge_res_available) converged <= has_converged;
      // A clear_iter landing on DONE takes priority over the increment.
      if (clear_iter) begin
        iter_count <= '0;
        stop       <= 1'b0;
      end else if (state == S_DONE) begin
        iter_count <= iter_nxt;
        if (converged || (max_iter != '0 && iter_nxt >= max_iter)) stop <= 1'b1;
      end
    end
  end

endmodule

// File: doc/centroid_update_sequencer.md
# centroid_update_sequencer

Drives the producer side of the new-centroid / convergence interface once per k-means iteration. On `start` it reads each cluster's accumulated coordinate sums and point count, divides them into a new centroid, and presents each centroid to the convergence checker with the correct strobes. It then collects the checker's verdict and reports iteration completion, convergence and iteration-limit stop to the top controller.

## Interface
- `centroid_num`, default 8: clusters per iteration.
- `cordinate_width`, default 13: centroid coordinate width.
- `accum_cord_width`, default 22: accumulated sum width per coordinate.
- `accum_width`, default 7*22: 7 sums, coordinate 1 in the LSBs.
- `count_width`, default 10: points-per-cluster count width.
- `dataWidth`, default 91: 7 × 13 packed centroid, coordinate 1 in the LSBs.
- `iter_width`, default 8: iteration counter width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse from the controller; accumulation is complete, so run one update pass.
- `clear_iter` in 1: pulse; clears `iter_count` and `stop`.
- `max_iter` in `iter_width`: iteration limit (0 means no limit).
- `sum_req` out 1: accumulator read strobe.
- `sum_idx` out 3: cluster index for the read.
- `accum_sum_in` in `accum_width`: sums, valid the cycle after `sum_req`.
- `count_in` in `count_width`: count, valid the cycle after `sum_req`.
- `new_centroid` out `dataWidth`: new centroid sent to the checker.
- `cent_num` out 3: centroid index sent to the checker.
- `divide_by_0` out 1: count was zero.
- `convergence_reg_en` out 1: checker count enable.
- `convergence_regs_reset_n` out 1: checker clear, active-low.
- `has_converged` in 1: checker verdict.
- `converge_res_available` in 1: verdict valid.
- `iter_done` out 1: one-cycle pulse at the end of a pass.
- `converged` out 1: verdict of the last pass.
- `stop` out 1: sticky; converged or limit reached.
- `iter_count` out `iter_width`: completed passes.

## Operation

**FSM states:** IDLE → CLEAR → FETCH → LOAD → DIV → EMIT → (FETCH | WAIT_RES) → DONE → IDLE.

- **IDLE:** waits for `start`. `start` is ignored in every other state. `start` while `stop`=1 is also ignored.
- **CLEAR:** `convergence_regs_reset_n`=0 for exactly 1 cycle; the index is set to 0.
- **FETCH:** `sum_req`=1 and `sum_idx`=index.
- **LOAD:**
  - Capture `accum_sum_in` and `count_in`.
  - If count=0, skip DIV and go to EMIT with quotient 0 and `divide_by_0`=1.
  - Otherwise start 7 parallel unsigned restoring divisions.
- **DIV:** one quotient bit per cycle per coordinate. Each quotient saturates to 2^13−1 if it exceeds 13 bits.
- **EMIT:** exactly one cycle.
  - `new_centroid`, `cent_num`=index, `divide_by_0` and `convergence_reg_en`=1 are all valid together.
  - If index<7, increment the index and go to FETCH; otherwise go to WAIT_RES.
- **Outside EMIT:** `cent_num`=0, `divide_by_0`=0, `convergence_reg_en`=0, and `new_centroid` holds its last value.
  - This is mandatory: the checker evaluates whenever `cent_num`=7.
- **WAIT_RES:** on `converge_res_available`=1, latch `has_converged` into `converged` and go to DONE.
- **DONE:**
  - `iter_done`=1 for one cycle and `iter_count` increments, saturating at all-ones.
  - `stop` is set if `converged`=1, or if `max_iter`≠0 and the new `iter_count` ≥ `max_iter`.
- **`clear_iter`** coinciding with DONE: clear wins.

## Timing
- **Reset values:**
  - All strobes 0, `new_centroid`=0, `cent_num`=0.
  - `iter_count`=0, `converged`=0, `stop`=0.
  - `convergence_regs_reset_n`=0 while `rst` is high (clears the checker), then 1.
  - FSM returns to IDLE.
- **Reset mid-pass:** any state, including DIV, aborts the pass to IDLE. No `iter_done` is produced.
- **Per-centroid latency** (rounding off): FETCH 1 + LOAD 1 + DIV 22 + EMIT 1 = 25 cycles. A zero count takes 3 cycles.
- **Pass latency:**
  - `start` sampled in cycle 0, CLEAR in cycle 1.
  - EMIT of centroid 7 in cycle 201 (all counts nonzero).
  - `converge_res_available` in cycle 202, `iter_done` in cycle 203.
- **Back-to-back passes:** `start` is accepted in the cycle after DONE.

## Configuration
- **`KMEANS_ROUND_DIV_EN` defined:**
  - Dividend = sum + (count>>1), 23 bits wide, giving round-to-nearest.
  - DIV takes 23 cycles, 26 cycles per centroid, so `iter_done` lands in cycle 211.
- **Undefined:** truncating division, timing as above.

## Structure
- **Package `kmeans_pkg`:**
  - FSM state enum.
  - Width constants (13, 22, 10, 91).
  - Coordinate-slice helper function.
- **Sub-module `coord_divider`:** one serial restoring divider with `load`/`busy`/`done` and saturation; 7 instances.

## Test plan
- **Basic pass:** every coordinate sum 1000, every count 10 → `new_centroid` = seven coordinates of 100 in each EMIT; `convergence_reg_en` in cycles 26, 51 … 201; `cent_num` 0…7 only there; `iter_done` in cycle 203.
- **Zero count:** cluster 3 count=0 → EMIT for cluster 3 has `divide_by_0`=1 and data 0; pass completes 22 cycles early (cycle 181).
- **Convergence:** `has_converged`=1 with `converge_res_available` → `converged`=1, `stop`=1, `iter_count`=1; the next `start` is ignored.
- **Iteration limit:** `max_iter`=3, `has_converged`=0 always → `stop` rises with the 3rd `iter_done`; `iter_count`=3; `clear_iter` → 0.
- **Reset mid-pass:** `rst` during DIV of cluster 5 → next cycle IDLE, all strobes 0, no `iter_done`; a fresh `start` runs a full pass.
- **Rounding:** with `KMEANS_ROUND_DIV_EN`, sum 1005 / count 10 → 101 (truncating build gives 100); saturation case sum 2^22−1 / count 1 → 8191.
